sysid_verify_ctrl: RTL

Boot-time controller that sequences reads of the system ID slave (word 0 = system ID, word 1 = generation timestamp) over Avalon-MM. It compares both words against the values the software image was built for, and drives sticky pass/fail status. It sits between the reset controller and the Nios II boot gate: `done && id_ok && ts_ok` releases audio/synth start-up, and `error` holds the system in a safe, muted state.

---
 rtl/sysid_verify_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sysid_verify_ctrl.sv
// rtl/sysid_verify_ctrl.sv - boot-time system ID / timestamp verification sequencer
//
// Reads word 0 (system ID) and word 1 (build timestamp) from the system ID
// slave over Avalon-MM, compares them with the values the software image was
// built for, retries whole passes on mismatch and reports sticky status.
//
// Ports:
//   clock_i          system clock, rising edge
//   reset_n_i        asynchronous active-low reset
//   start_i          start pulse, honoured only in IDLE or DONE
//   m_address_o      word select (0 = ID, 1 = timestamp)
//   m_read_o         Avalon read request
//   m_waitrequest_i  slave stall
//   m_readdata_i     slave read data
//   busy_o           sequence in progress
//   done_o           sequence finished, held until the next accepted start
//   id_ok_o          word 0 matched on the final pass
//   ts_ok_o          word 1 matched on the final pass
//   error_o          final pass mismatched or a read timed out
//   timeout_o        a read was aborted by the stall timeout
//   captured_id_o    last captured word 0
//   captured_ts_o    last captured word 1

module sysid_verify_ctrl #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1427243257,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        start_i,
    output logic        m_address_o,
    output logic        m_read_o,
    input  logic        m_waitrequest_i,
    input  logic [31:0] m_readdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        id_ok_o,
    output logic        ts_ok_o,
    output logic        error_o,
    output logic        timeout_o,
    output logic [31:0] captured_id_o,
    output logic [31:0] captured_ts_o
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Index of the final latency cycle; only meaningful when READ_LATENCY > 0.
    localparam logic [1:0] LAT_LAST = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_WAIT_ID,
        S_RD_TS,
        S_WAIT_TS,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] to_q, to_d;
    logic [1:0]    lat_q, lat_d;
    logic          id_ok_q, id_ok_d;
    logic          ts_ok_q, ts_ok_d;
    logic          error_q, error_d;
    logic          timeout_q, timeout_d;
    logic [31:0]   cap_id_q, cap_id_d;
    logic [31:0]   cap_ts_q, cap_ts_d;

    logic          to_hit;
    logic [TW-1:0] to_inc;
    logic          id_match;
    logic          ts_match;

    // This stall cycle is the one that brings the count up to TIMEOUT_CYCLES.
    assign to_hit   = (32'(to_q) + 32'd1) >= TIMEOUT_CYCLES;
    assign to_inc   = (&to_q) ? to_q : to_q + TW'(1);
    assign id_match = (cap_id_q == EXPECTED_ID);
    assign ts_match = (cap_ts_q == EXPECTED_TS);

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        to_d      = to_q;
        lat_d     = lat_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d   = S_RD_ID;
                    retry_d   = '0;
                    to_d      = '0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!m_waitrequest_i) begin
                    to_d = '0;
                    if (READ_LATENCY == 0) begin
                        if (state_q == S_RD_ID) begin
                            cap_id_d = m_readdata_i;
                            state_d  = S_RD_TS;
                        end else begin
                            cap_ts_d = m_readdata_i;
                            state_d  = S_CHECK;
                        end
                    end else begin
                        lat_d   = 2'd0;
                        state_d = (state_q == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
                    end
                end else if (to_hit) begin
                    // A stuck slave is not worth retrying.
                    state_d   = S_DONE;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    to_d = to_inc;
                end
            end
            S_WAIT_ID: begin
                if (lat_q == LAT_LAST) begin
                    cap_id_d = m_readdata_i;
                    state_d  = S_RD_TS;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_WAIT_TS: begin
                if (lat_q == LAT_LAST) begin
                    cap_ts_d = m_readdata_i;
                    state_d  = S_CHECK;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_CHECK: begin
                if (id_match && ts_match) begin
                    state_d = S_DONE;
                    id_ok_d = 1'b1;
                    ts_ok_d = 1'b1;
                end else if (32'(retry_q) < MAX_RETRIES) begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_RD_ID;
                end else begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                    id_ok_d = id_match;
                    ts_ok_d = ts_match;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            retry_q   <= '0;
            to_q      <= '0;
            lat_q     <= 2'd0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= 32'd0;
            cap_ts_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            to_q      <= to_d;
            lat_q     <= lat_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    // Bus and status strobes decode straight from the state register so they
    // drop together with it on reset; address stays put through stalls and
    // the latency wait of each word.
    assign m_read_o      = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    assign m_address_o   = (state_q == S_RD_TS) || (state_q == S_WAIT_TS);
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o        = (state_q == S_DONE);
    assign id_ok_o       = id_ok_q;
    assign ts_ok_o       = ts_ok_q;
    assign error_o       = error_q;
    assign timeout_o     = timeout_q;
    assign captured_id_o = cap_id_q;
    assign captured_ts_o = cap_ts_q;

endmodule
